// File: rtl/led_strip_decoder_if.sv
// rtl/led_strip_decoder_if.sv - strip input and decoded pixel bundle for led_strip_decoder
interface led_strip_decoder_if #(
  parameter int NUM_LEDS = 64
);
  localparam int IW = $clog2(NUM_LEDS);

  logic          strip_clk;
  logic          strip_data;
  logic          pix_valid;
  logic [IW-1:0] pix_idx;
  logic [4:0]    pix_bright;
  logic [7:0]    pix_blue;
  logic [7:0]    pix_green;
  logic [7:0]    pix_red;
  logic          frame_done;
  logic          frame_err;
  logic [1:0]    err_code;
  logic          in_frame;

  modport slave (
    input  strip_clk, strip_data,
    output pix_valid, pix_idx, pix_bright, pix_blue, pix_green, pix_red,
    output frame_done, frame_err, err_code, in_frame
  );

  modport master (
    output strip_clk, strip_data,
    input  pix_valid, pix_idx, pix_bright, pix_blue, pix_green, pix_red,
    input  frame_done, frame_err, err_code, in_frame
  );
endinterface

// File: rtl/led_strip_decoder.sv
// rtl/led_strip_decoder.sv - two-wire LED strip frame decoder (pixels, frame done/error)
// Optional LED_DECODE_SNAKE_EN: remap pix_idx to raster order of an 8-wide serpentine matrix.
module led_strip_decoder #(
  parameter int NUM_LEDS   = 64,
  parameter int START_BITS = 32,
  parameter int END_BITS   = 64,
  parameter int TIMEOUT    = 4096
) (
  input logic clk,
  input logic reset_n,
  led_strip_decoder_if.slave bus
);
  localparam int IW   = $clog2(NUM_LEDS);
  localparam int CMAX = (END_BITS > START_BITS) ? END_BITS : START_BITS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT, WORD, ENDF} state_t;

  state_t        state_q, state_d;
  logic          sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
  logic          sdat_s1_q, sdat_s1_d, sdat_s2_q, sdat_s2_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bcnt_q, bcnt_d;
  logic [IW-1:0] widx_q, widx_d;
  logic [30:0]   shreg_q, shreg_d;
  logic          pix_valid_q, pix_valid_d;
  logic [IW-1:0] pix_idx_q, pix_idx_d;
  logic [4:0]    pix_bright_q, pix_bright_d;
  logic [7:0]    pix_blue_q, pix_blue_d, pix_green_q, pix_green_d, pix_red_q, pix_red_d;
  logic          frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          in_frame_q, in_frame_d;

  logic          fall, any_edge, bit_in, timeout, abort;
  logic [1:0]    abort_code;
  logic [31:0]   word_in;

  function automatic logic [IW-1:0] map_idx(input logic [IW-1:0] w);
`ifdef LED_DECODE_SNAKE_EN
    // Even rows run right-to-left on the strip, so mirror the column.
    return w[3] ? w : {w[IW-1:3], ~w[2:0]};
`else
    return w;
`endif
  endfunction

  assign fall     = sclk_prev_q & ~sclk_s2_q;
  assign any_edge = sclk_prev_q ^ sclk_s2_q;
  assign bit_in   = sdat_s2_q;
  assign timeout  = (tcnt_q == TW'(TIMEOUT));
  assign word_in  = {shreg_q, bit_in};

  always_comb begin
    state_d      = state_q;
    sclk_s1_d    = bus.strip_clk;
    sclk_s2_d    = sclk_s1_q;
    sclk_prev_d  = sclk_s2_q;
    sdat_s1_d    = bus.strip_data;
    sdat_s2_d    = sdat_s1_q;
    tcnt_d       = any_edge ? '0 : (timeout ? tcnt_q : tcnt_q + 1'b1);
    cnt_d        = cnt_q;
    bcnt_d       = bcnt_q;
    widx_d       = widx_q;
    shreg_d      = shreg_q;
    pix_valid_d  = 1'b0;
    pix_idx_d    = pix_idx_q;
    pix_bright_d = pix_bright_q;
    pix_blue_d   = pix_blue_q;
    pix_green_d  = pix_green_q;
    pix_red_d    = pix_red_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    in_frame_d   = in_frame_q;
    abort        = 1'b0;
    abort_code   = 2'd0;

    case (state_q)
      HUNT: begin
        if (fall) begin
          if (!bit_in) begin
            if (cnt_q != CW'(START_BITS)) cnt_d = cnt_q + 1'b1;
          end else if (cnt_q == CW'(START_BITS)) begin
            shreg_d    = 31'd1;
            bcnt_d     = 5'd1;
            in_frame_d = 1'b1;
            state_d    = WORD;
          end else begin
            cnt_d = '0;
          end
        end
      end
      WORD: begin
        if (timeout) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else if (fall) begin
          shreg_d = word_in[30:0];
          if (bcnt_q == 5'd31) begin
            bcnt_d = 5'd0;
            if (word_in[31:29] == 3'b111) begin
              pix_valid_d  = 1'b1;
              pix_idx_d    = map_idx(widx_q);
              pix_bright_d = word_in[28:24];
              pix_blue_d   = word_in[23:16];
              pix_green_d  = word_in[15:8];
              pix_red_d    = word_in[7:0];
              if (widx_q == IW'(NUM_LEDS - 1)) begin
                widx_d  = '0;
                cnt_d   = '0;
                state_d = ENDF;
              end else begin
                widx_d = widx_q + 1'b1;
              end
            end else begin
              abort      = 1'b1;
              abort_code = 2'd1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      ENDF: begin
        if (timeout) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else if (fall) begin
          if (bit_in) begin
            abort      = 1'b1;
            abort_code = 2'd2;
          end else if (cnt_q == CW'(END_BITS - 1)) begin
            frame_done_d = 1'b1;
            in_frame_d   = 1'b0;
            cnt_d        = '0;
            state_d      = HUNT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (abort) begin
      frame_err_d = 1'b1;
      err_code_d  = abort_code;
      in_frame_d  = 1'b0;
      cnt_d       = '0;
      bcnt_d      = '0;
      widx_d      = '0;
      state_d     = HUNT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      sclk_s1_q    <= 1'b0;
      sclk_s2_q    <= 1'b0;
      sclk_prev_q  <= 1'b0;
      sdat_s1_q    <= 1'b0;
      sdat_s2_q    <= 1'b0;
      tcnt_q       <= '0;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      widx_q       <= '0;
      shreg_q      <= '0;
      pix_valid_q  <= 1'b0;
      pix_idx_q    <= '0;
      pix_bright_q <= '0;
      pix_blue_q   <= '0;
      pix_green_q  <= '0;
      pix_red_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
      in_frame_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_s1_q    <= sclk_s1_d;
      sclk_s2_q    <= sclk_s2_d;
      sclk_prev_q  <= sclk_prev_d;
      sdat_s1_q    <= sdat_s1_d;
      sdat_s2_q    <= sdat_s2_d;
      tcnt_q       <= tcnt_d;
      cnt_q        <= cnt_d;
      bcnt_q       <= bcnt_d;
      widx_q       <= widx_d;
      shreg_q      <= shreg_d;
      pix_valid_q  <= pix_valid_d;
      pix_idx_q    <= pix_idx_d;
      pix_bright_q <= pix_bright_d;
      pix_blue_q   <= pix_blue_d;
      pix_green_q  <= pix_green_d;
      pix_red_q    <= pix_red_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      in_frame_q   <= in_frame_d;
    end
  end

  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_idx    = pix_idx_q;
  assign bus.pix_bright = pix_bright_q;
  assign bus.pix_blue   = pix_blue_q;
  assign bus.pix_green  = pix_green_q;
  assign bus.pix_red    = pix_red_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_code   = err_code_q;
  assign bus.in_frame   = in_frame_q;
endmodule

// File: tb/tb_led_strip_decoder.sv
// tb/tb_led_strip_decoder.sv - randomized frame stimulus against a word-level pixel model
module tb_led_strip_decoder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  led_strip_decoder_if #(.NUM_LEDS(64)) bus();
  led_strip_decoder dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct packed {
    logic [5:0] idx;
    logic [4:0] br;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pix_t;

  pix_t        got_q[$];
  int          n_done = 0;
  int          n_err = 0;
  int          n_both = 0;
  int          total = 0;
  int          bad = 0;
  int          p_base, d_base, e_base;
  logic [31:0] words[64];

  always @(negedge clk) begin
    if (bus.pix_valid)
      got_q.push_back({bus.pix_idx, bus.pix_bright, bus.pix_blue, bus.pix_green, bus.pix_red});
    if (bus.frame_done) n_done++;
    if (bus.frame_err) n_err++;
    if (bus.frame_done && bus.frame_err) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_idx(input int i);
`ifdef LED_DECODE_SNAKE_EN
    if ((i / 8) % 2 == 0) return (i / 8) * 8 + 7 - (i % 8);
`endif
    return i;
  endfunction

  task automatic send_bit(input logic b);
    bus.strip_data = b;
    bus.strip_clk  = 1'b1;
    repeat ($urandom_range(3, 4)) @(posedge clk);
    #1 bus.strip_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = 31; i > 31 - nbits; i--) send_bit(w[i]);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 64; i++) words[i] = {3'b111, 29'($urandom)};
  endtask

  task automatic begin_frame();
    p_base = got_q.size();
    d_base = n_done;
    e_base = n_err;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " pix_valid"}, 32'(bus.pix_valid), 0);
    chk({tag, " pix_fields"}, {bus.pix_idx, bus.pix_bright, bus.pix_blue, bus.pix_red}, 0);
    chk({tag, " pix_green"}, 32'(bus.pix_green), 0);
    chk({tag, " done_err"}, {bus.frame_done, bus.frame_err}, 0);
    chk({tag, " err_code"}, 32'(bus.err_code), 0);
    chk({tag, " in_frame"}, 32'(bus.in_frame), 0);
  endtask

  // Expected pixels: words in order up to (not including) the first bad header.
  task automatic frame_result(input string tag, input int nw, input int done_exp,
                              input int err_exp, input logic [1:0] code_exp);
    int   k;
    pix_t p;
    repeat (20) @(posedge clk);
    #1;
    k = 0;
    for (int i = 0; i < nw; i++) begin
      if (words[i][31:29] != 3'b111) break;
      if (p_base + k < got_q.size()) begin
        p = got_q[p_base + k];
        chk($sformatf("%s idx%0d", tag, i), 32'(p.idx), exp_idx(i));
        chk($sformatf("%s data%0d", tag, i), {3'b0, p.br, p.b, p.g, p.r},
            {3'b0, words[i][28:0]});
      end
      k++;
    end
    chk({tag, " npix"}, got_q.size() - p_base, k);
    chk({tag, " frame_done"}, n_done - d_base, done_exp);
    chk({tag, " frame_err"}, n_err - e_base, err_exp);
    chk({tag, " err_code"}, 32'(bus.err_code), 32'(code_exp));
    chk({tag, " in_frame"}, 32'(bus.in_frame), 0);
  endtask

  initial begin
    bus.strip_clk  = 1'b0;
    bus.strip_data = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk_idle("reset");
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 64; i++) words[i] = 32'hF00F0000;
    begin_frame();
    send_zeros(32);
    for (int i = 0; i < 64; i++) send_word(words[i], 32);
    send_zeros(64);
    frame_result("nominal", 64, 1, 0, 2'd0);

    rand_words();
    words[5] = 32'h70000000;
    begin_frame();
    send_zeros(32);
    for (int i = 0; i < 6; i++) send_word(words[i], 32);
    send_zeros(64);
    frame_result("badhdr", 6, 0, 1, 2'd1);

    rand_words();
    words[3] = 32'hFF123456;
    begin_frame();
    send_zeros(32);
    for (int i = 0; i < 64; i++) send_word(words[i], 32);
    send_zeros(64);
    frame_result("mixed", 64, 1, 0, 2'd1);

    rand_words();
    begin_frame();
    send_zeros(31);
    for (int i = 0; i < 2; i++) send_word(words[i], 32);
    send_zeros(64);
    frame_result("shortstart", 0, 0, 0, 2'd1);

    rand_words();
    begin_frame();
    send_zeros(32);
    for (int i = 0; i < 64; i++) send_word(words[i], 32);
    send_zeros(39);
    send_bit(1'b1);
    send_zeros(64);
    frame_result("enderr", 64, 0, 1, 2'd2);

    rand_words();
    begin_frame();
    send_zeros(32);
    for (int i = 0; i < 2; i++) send_word(words[i], 32);
    send_word(words[2], 10);
    chk("timeout in_frame_mid", 32'(bus.in_frame), 1);
    repeat (4200) @(posedge clk);
    frame_result("timeout", 2, 0, 1, 2'd3);

    rand_words();
    begin_frame();
    send_zeros(32);
    send_word(words[0], 32);
    send_word(words[1], 5);
    reset_n = 1'b0;
    #1 chk_idle("midreset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("midreset no_err", n_err - e_base, 0);

    rand_words();
    begin_frame();
    send_zeros(32);
    for (int i = 0; i < 64; i++) send_word(words[i], 32);
    send_zeros(64);
    frame_result("postreset", 64, 1, 0, 2'd0);

    chk("done_err_exclusive", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
